decode_stage: RTL

- Registered, parametrised RV32I instruction decode stage with valid/ready handshakes on both sides.
- An internal DEPTH-entry FIFO of decoded bundles decouples fetch from execute.
- Detects illegal encodings and supports a pipeline flush.
- Sits between the fetch unit and the register-read/execute stage; the decoded-field encodings are those of define.v (ALU_OP_*, ALU_ASRC_*, ALU_BSRC_*, BRANCH_*).

---
 rtl/decode_stage.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a DEPTH-entry FIFO of bundles.
// Define DECODE_MEXT_EN to accept M-extension OP encodings (funct7=0000001).
module decode_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32
) (
  input  logic            Clk_i,
  input  logic            Rst_i,
  input  logic            Flush_i,
  input  logic            InstrValid_i,
  output logic            InstrReady_o,
  input  logic [31:0]     Instr_i,
  input  logic [PC_W-1:0] Pc_i,
  output logic            DecValid_o,
  input  logic            DecReady_i,
  output logic [PC_W-1:0] Pc_o,
  output logic [4:0]      Rs1_o,
  output logic [4:0]      Rs2_o,
  output logic [4:0]      Rd_o,
  output logic [31:0]     IMM_o,
  output logic [2:0]      Branch_o,
  output logic            RegWrite_en_o,
  output logic            MemWrite_en_o,
  output logic            Mem2Reg_o,
  output logic [2:0]      MemOP_o,
  output logic            ALU_Asrc_o,
  output logic [1:0]      ALU_Bsrc_o,
  output logic [3:0]      ALUctr_o,
  output logic            MulDiv_o,
  output logic            Illegal_o,
  output logic [15:0]     IllegalCnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OP_SLL  = 4'b0001;
  localparam logic [3:0] ALU_OP_SLT  = 4'b0010;
  localparam logic [3:0] ALU_OP_SLTU = 4'b0011;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OP_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OP_OR   = 4'b0110;
  localparam logic [3:0] ALU_OP_AND  = 4'b0111;
  localparam logic [3:0] ALU_OP_SUB  = 4'b1000;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OP_LUI  = 4'b1111;

  localparam logic       ALU_ASRC_REG = 1'b0;
  localparam logic       ALU_ASRC_PC  = 1'b1;
  localparam logic [1:0] ALU_BSRC_REG = 2'b00;
  localparam logic [1:0] ALU_BSRC_IMM = 2'b01;
  localparam logic [1:0] ALU_BSRC_4   = 2'b10;

  localparam logic [2:0] BRANCH_DISABLE = 3'b000;
  localparam logic [2:0] BRANCH_JAL     = 3'b010;
  localparam logic [2:0] BRANCH_JALR    = 3'b011;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [2:0]      branch;
    logic            regwrite;
    logic            memwrite;
    logic            mem2reg;
    logic [2:0]      memop;
    logic            asrc;
    logic [1:0]      bsrc;
    logic [3:0]      aluctr;
    logic            muldiv;
    logic            illegal;
  } bundle_t;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [3:0]  w_alu_f3;
  logic        w_illegal;
  bundle_t     w_dec;

  assign w_opcode = Instr_i[6:0];
  assign w_funct3 = Instr_i[14:12];
  assign w_funct7 = Instr_i[31:25];

  assign w_imm_i = {{20{Instr_i[31]}}, Instr_i[31:20]};
  assign w_imm_s = {{20{Instr_i[31]}}, Instr_i[31:25], Instr_i[11:7]};
  assign w_imm_b = {{19{Instr_i[31]}}, Instr_i[31], Instr_i[7], Instr_i[30:25],
                    Instr_i[11:8], 1'b0};
  assign w_imm_u = {Instr_i[31:12], 12'h000};
  assign w_imm_j = {{11{Instr_i[31]}}, Instr_i[31], Instr_i[19:12], Instr_i[20],
                    Instr_i[30:21], 1'b0};

  always_comb begin
    unique case (w_funct3)
      3'b000:  w_alu_f3 = ALU_OP_ADD;
      3'b001:  w_alu_f3 = ALU_OP_SLL;
      3'b010:  w_alu_f3 = ALU_OP_SLT;
      3'b011:  w_alu_f3 = ALU_OP_SLTU;
      3'b100:  w_alu_f3 = ALU_OP_XOR;
      3'b101:  w_alu_f3 = ALU_OP_SRL;
      3'b110:  w_alu_f3 = ALU_OP_OR;
      default: w_alu_f3 = ALU_OP_AND;
    endcase
  end

  always_comb begin
    w_dec          = '0;
    w_dec.pc       = Pc_i;
    w_dec.rs1      = Instr_i[19:15];
    w_dec.rs2      = Instr_i[24:20];
    w_dec.rd       = Instr_i[11:7];
    w_dec.branch   = BRANCH_DISABLE;
    w_dec.asrc     = ALU_ASRC_REG;
    w_dec.bsrc     = ALU_BSRC_REG;
    w_dec.aluctr   = ALU_OP_ADD;
    w_illegal      = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_dec.imm      = w_imm_u;
        w_dec.aluctr   = ALU_OP_LUI;
        w_dec.regwrite = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.imm      = w_imm_u;
        w_dec.asrc     = ALU_ASRC_PC;
        w_dec.bsrc     = ALU_BSRC_IMM;
        w_dec.regwrite = 1'b1;
      end
      OPC_JAL: begin
        w_dec.imm      = w_imm_j;
        w_dec.asrc     = ALU_ASRC_PC;
        w_dec.bsrc     = ALU_BSRC_4;
        w_dec.branch   = BRANCH_JAL;
        w_dec.regwrite = 1'b1;
      end
      OPC_JALR: begin
        w_dec.imm      = w_imm_i;
        w_dec.asrc     = ALU_ASRC_PC;
        w_dec.bsrc     = ALU_BSRC_4;
        w_dec.branch   = BRANCH_JALR;
        w_dec.regwrite = 1'b1;
        w_illegal      = (w_funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_dec.imm    = w_imm_b;
        w_dec.branch = w_funct3;
        w_illegal    = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      OPC_LOAD: begin
        w_dec.imm      = w_imm_i;
        w_dec.bsrc     = ALU_BSRC_IMM;
        w_dec.mem2reg  = 1'b1;
        w_dec.memop    = w_funct3;
        w_dec.regwrite = 1'b1;
        w_illegal      = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        w_dec.imm      = w_imm_s;
        w_dec.bsrc     = ALU_BSRC_IMM;
        w_dec.memwrite = 1'b1;
        w_dec.memop    = w_funct3;
        w_illegal      = (w_funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        w_dec.imm      = w_imm_i;
        w_dec.bsrc     = ALU_BSRC_IMM;
        w_dec.regwrite = 1'b1;
        w_dec.aluctr   = (w_funct3 == 3'b101 && Instr_i[30]) ? ALU_OP_SRA : w_alu_f3;
        if (w_funct3 == 3'b001) begin
          w_illegal = (w_funct7 != 7'b0000000);
        end else if (w_funct3 == 3'b101) begin
          w_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
        end
      end
      OPC_OP: begin
        w_dec.bsrc     = ALU_BSRC_REG;
        w_dec.regwrite = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          w_dec.aluctr = w_alu_f3;
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          w_dec.aluctr = ALU_OP_SUB;
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
          w_dec.aluctr = ALU_OP_SRA;
`ifdef DECODE_MEXT_EN
        end else if (w_funct7 == 7'b0000001) begin
          // Multiply/divide unit selects its operation from funct3 carried on MemOP.
          w_dec.muldiv = 1'b1;
          w_dec.aluctr = ALU_OP_ADD;
          w_dec.memop  = w_funct3;
`endif
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_dec.regwrite = 1'b0;
      w_dec.memwrite = 1'b0;
      w_dec.branch   = BRANCH_DISABLE;
      w_dec.aluctr   = 4'b0000;
    end
    w_dec.illegal = w_illegal;
  end

  bundle_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_ill_cnt;
  logic          w_full;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  bundle_t       w_head;

  assign w_full       = (r_count == FULL_CNT);
  assign w_valid      = (r_count != '0);
  assign InstrReady_o = !Rst_i && !w_full;
  assign w_push       = InstrValid_i && InstrReady_o && !Flush_i;
  assign w_pop        = w_valid && DecReady_i && !Flush_i;

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (Flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_dec;
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_ill_cnt <= '0;
    end else if (w_push && w_dec.illegal && r_ill_cnt != 16'hFFFF) begin
      r_ill_cnt <= r_ill_cnt + 16'd1;
    end
  end

  assign w_head = w_valid ? r_mem[r_rptr] : '0;

  assign DecValid_o    = w_valid;
  assign Pc_o          = w_head.pc;
  assign Rs1_o         = w_head.rs1;
  assign Rs2_o         = w_head.rs2;
  assign Rd_o          = w_head.rd;
  assign IMM_o         = w_head.imm;
  assign Branch_o      = w_head.branch;
  assign RegWrite_en_o = w_head.regwrite;
  assign MemWrite_en_o = w_head.memwrite;
  assign Mem2Reg_o     = w_head.mem2reg;
  assign MemOP_o       = w_head.memop;
  assign ALU_Asrc_o    = w_head.asrc;
  assign ALU_Bsrc_o    = w_head.bsrc;
  assign ALUctr_o      = w_head.aluctr;
  assign MulDiv_o      = w_head.muldiv;
  assign Illegal_o     = w_head.illegal;
  assign IllegalCnt_o  = r_ill_cnt;

endmodule
